// File: rtl/approx_adder_bist.sv
// Built-in self-test engine for an approximate adder.
// Drives pseudo-random operand pairs from a 32-bit LFSR into an external
// combinational adder, compares its result against the exact sum and
// accumulates error count, error-distance sum and worst-case distance.
module approx_adder_bist #(
  parameter int W     = 16,
  parameter int CNT_W = 18,
  parameter int ACC_W = W + 1 + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [31:0]      seed,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [W:0]       dut_res,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] err_sum,
  output logic [W:0]       err_max
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [31:0]      r_lfsr;
  logic [CNT_W-1:0] r_numVec;
  logic [CNT_W-1:0] r_vecCnt;
  logic             r_busy;
  logic             r_valid;
  logic             r_mis;
  logic [W:0]       r_dist;
  logic [CNT_W-1:0] r_errCount;
  logic [ACC_W-1:0] r_errSum;
  logic [W:0]       r_errMax;

  logic             w_startAccept;
  logic             w_lastVec;
  logic [31:0]      w_lfsrNext;
  logic [W:0]       w_exact;
  logic [W:0]       w_dist;

  // A start request is only honoured when no run is in flight.
  assign w_startAccept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_lastVec     = (r_vecCnt == (r_numVec - CNT_W'(1)));
  assign w_lfsrNext    = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};

  // Operands come straight from the LFSR so the seed itself is the first vector.
  assign op_a = r_lfsr[W-1:0];
  assign op_b = r_lfsr[31:32-W];

  // Exact reference sum and unsigned distance of the adder result from it.
  assign w_exact = {1'b0, op_a} + {1'b0, op_b};
  assign w_dist  = (dut_res >= w_exact) ? (dut_res - w_exact) : (w_exact - dut_res);

  assign busy      = r_busy;
  assign done      = (r_state == DONE);
  assign err_count = r_errCount;
  assign err_sum   = r_errSum;
  assign err_max   = r_errMax;

  // State register; reset wins over any simultaneous start.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic: a zero-length run skips straight to the one-cycle drain.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_startAccept) w_nextState = (num_vectors == '0) ? DRAIN : RUN;
      end
      RUN: begin
        if (w_lastVec) w_nextState = DRAIN;
      end
      DRAIN:   w_nextState = DONE;
      default: w_nextState = IDLE;
    endcase
  end

  // LFSR, vector counter and busy flag; the LFSR only advances in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr   <= 32'h1;
      r_numVec <= '0;
      r_vecCnt <= '0;
      r_busy   <= 1'b0;
    end else if (w_startAccept) begin
      r_lfsr   <= (seed == 32'h0) ? 32'h1 : seed;
      r_numVec <= num_vectors;
      r_vecCnt <= '0;
      r_busy   <= (num_vectors != '0);
    end else if (r_state == RUN) begin
      r_lfsr   <= w_lfsrNext;
      r_vecCnt <= r_vecCnt + CNT_W'(1);
    end else if (r_state == DRAIN) begin
      r_busy   <= 1'b0;
    end
  end

  // Stage 1: capture the error distance of the vector presented this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_dist  <= '0;
      r_mis   <= 1'b0;
    end else begin
      r_valid <= (r_state == RUN);
      if (r_state == RUN) begin
        r_dist <= w_dist;
        r_mis  <= (w_dist != '0);
      end
    end
  end

  // Stage 2: fold the captured distance into the run statistics.
  always_ff @(posedge clk) begin
    if (rst || w_startAccept) begin
      r_errCount <= '0;
      r_errSum   <= '0;
      r_errMax   <= '0;
    end else if (r_valid) begin
      r_errCount <= r_errCount + CNT_W'(r_mis);
      r_errSum   <= r_errSum + ACC_W'(r_dist);
      if (r_dist > r_errMax) r_errMax <= r_dist;
    end
  end

endmodule

// File: tb/tb_approx_adder_bist.sv
// Self-checking bench for approx_adder_bist: directed table of runs with
// a reference model of the operand stream, plus hand-written sequences for
// reset, ignored starts and restart from DONE.
module tb_approx_adder_bist;

  localparam int W     = 16;
  localparam int CNT_W = 18;
  localparam int ACC_W = W + 1 + CNT_W;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] numVectors;
  logic [31:0]      seed;
  logic [W-1:0]     opA;
  logic [W-1:0]     opB;
  logic [W:0]       dutRes;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] errCount;
  logic [ACC_W-1:0] errSum;
  logic [W:0]       errMax;
  logic [1:0]       mode;

  int nApplied;
  int nMiscompares;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [31:0] seed;
    int          n;
    bit          useModel;
    longint      expCnt;
    longint      expSum;
    longint      expMax;
  } vec_t;

  vec_t vecs[10];

  approx_adder_bist #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(numVectors), .seed(seed),
    .op_a(opA), .op_b(opB), .dut_res(dutRes), .busy(busy), .done(done),
    .err_count(errCount), .err_sum(errSum), .err_max(errMax)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder under test: mode 0 exact, 1 forces LSB high, 2 stuck at zero,
  // 3 lower-part-OR approximation on the bottom four bits.
  function automatic logic [16:0] adderModel(input logic [15:0] a, input logic [15:0] b,
                                             input logic [1:0] m);
    logic [16:0] ex;
    ex = {1'b0, a} + {1'b0, b};
    case (m)
      2'd0:    adderModel = ex;
      2'd1:    adderModel = ex | 17'd1;
      2'd2:    adderModel = 17'd0;
      default: adderModel = {({1'b0, a[15:4]} + {1'b0, b[15:4]}), a[3:0] | b[3:0]};
    endcase
  endfunction

  // External adder responds combinationally to the operands.
  always_comb dutRes = adderModel(opA, opB, mode);

  // Reference: walk the operand stream and accumulate expected statistics.
  task automatic modelRun(input logic [31:0] s, input int n, input logic [1:0] m,
                          output longint cnt, output longint sum, output longint mx);
    logic [31:0] l;
    logic [16:0] ex;
    logic [16:0] res;
    logic [16:0] d;
    l = (s == 32'h0) ? 32'h1 : s;
    cnt = 0; sum = 0; mx = 0;
    for (int i = 0; i < n; i++) begin
      ex  = {1'b0, l[15:0]} + {1'b0, l[31:16]};
      res = adderModel(l[15:0], l[31:16], m);
      d   = (res >= ex) ? (res - ex) : (ex - res);
      if (d != 17'd0) cnt++;
      sum += longint'(d);
      if (longint'(d) > mx) mx = longint'(d);
      l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkStats(input string name, input longint eCnt, input longint eSum,
                            input longint eMax);
    checkOutput({name, " err_count"}, 64'(errCount), 64'(eCnt));
    checkOutput({name, " err_sum"},   64'(errSum),   64'(eSum));
    checkOutput({name, " err_max"},   64'(errMax),   64'(eMax));
  endtask

  // Launch one run and check it; optionally pulse start in RUN and/or DRAIN.
  // Cycle 0 is the cycle in which start is sampled; done must appear in cycle n+2.
  task automatic applyStimulus(input string name, input logic [1:0] m, input logic [31:0] s,
                               input int n, input longint eCnt, input longint eSum,
                               input longint eMax, input int pulseRunAt, input bit pulseDrain);
    int c;
    logic [31:0] first;
    first = (s == 32'h0) ? 32'h1 : s;
    @(negedge clk);
    mode = m; seed = s; numVectors = CNT_W'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    checkOutput({name, " first op_a"}, 64'(opA), 64'(first[15:0]));
    checkOutput({name, " first op_b"}, 64'(opB), 64'(first[31:16]));
    checkOutput({name, " busy start"}, 64'(busy), 64'(n != 0));
    checkStats({name, " cleared"}, 0, 0, 0);
    while (!done && c < n + 10) begin
      if (c == pulseRunAt || (pulseDrain && c == n + 1)) begin
        start = 1'b1; numVectors = CNT_W'(7); seed = 32'd99;
      end
      @(negedge clk);
      start = 1'b0;
      c++;
    end
    checkOutput({name, " done latency"}, 64'(c), 64'(n + 2));
    checkOutput({name, " busy at done"}, 64'(busy), 64'd0);
    checkStats(name, eCnt, eSum, eMax);
    repeat (3) @(negedge clk);
    checkOutput({name, " done held"}, 64'(done), 64'd1);
    checkStats({name, " held"}, eCnt, eSum, eMax);
  endtask

  initial begin
    longint mc, ms, mm;
    int c;
    nApplied = 0; nMiscompares = 0;
    rst = 1'b1; start = 1'b0; numVectors = '0; seed = '0; mode = 2'd0;

    vecs[0] = '{"exact1000", 2'd0, 32'hACE1,     1000, 1'b0, 0, 0, 0};
    vecs[1] = '{"zeroN",     2'd0, 32'h5,        0,    1'b0, 0, 0, 0};
    vecs[2] = '{"stuck1",    2'd2, 32'h0,        1,    1'b0, 1, 1, 1};
    vecs[3] = '{"stuck2",    2'd2, 32'h1,        2,    1'b0, 2, 4, 3};
    vecs[4] = '{"lsbOdd",    2'd1, 32'h1,        2,    1'b0, 0, 0, 0};
    vecs[5] = '{"lsbEven",   2'd1, 32'h2,        1,    1'b0, 1, 1, 1};
    vecs[6] = '{"lsb4096",   2'd1, 32'hACE1,     4096, 1'b1, 0, 0, 0};
    vecs[7] = '{"stuck300",  2'd2, 32'h0,        300,  1'b1, 0, 0, 0};
    vecs[8] = '{"lpoa500",   2'd3, 32'h12345678, 500,  1'b1, 0, 0, 0};
    vecs[9] = '{"exact1",    2'd0, 32'hFFFFFFFF, 1,    1'b0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].useModel) begin
        modelRun(vecs[i].seed, vecs[i].n, vecs[i].mode, mc, ms, mm);
        vecs[i].expCnt = mc; vecs[i].expSum = ms; vecs[i].expMax = mm;
      end
    end
    vecs[6].expMax = 1;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkStats("reset", 0, 0, 0);
    checkOutput("reset op_a", 64'(opA), 64'd1);
    checkOutput("reset op_b", 64'(opB), 64'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i].name, vecs[i].mode, vecs[i].seed, vecs[i].n,
                    vecs[i].expCnt, vecs[i].expSum, vecs[i].expMax, 0, 1'b0);

    // start pulsed in RUN and in DRAIN must be ignored
    modelRun(32'h1234ABCD, 20, 2'd3, mc, ms, mm);
    applyStimulus("ignoredStart", 2'd3, 32'h1234ABCD, 20, mc, ms, mm, 5, 1'b1);

    // start from DONE clears statistics and begins a fresh run
    modelRun(32'h7, 50, 2'd1, mc, ms, mm);
    applyStimulus("restartDone", 2'd1, 32'h7, 50, mc, ms, mm, 0, 1'b0);

    // rst together with start in DONE: reset wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1; numVectors = CNT_W'(5); seed = 32'h55;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checkOutput("rstStart busy", 64'(busy), 64'd0);
    checkOutput("rstStart done", 64'(done), 64'd0);
    checkStats("rstStart", 0, 0, 0);
    @(negedge clk);
    checkOutput("rstStart idle busy", 64'(busy), 64'd0);

    // rst in the 50th RUN cycle of a 1000-vector run
    @(negedge clk);
    mode = 2'd3; seed = 32'hACE1; numVectors = CNT_W'(1000); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (c < 50) begin
      @(negedge clk);
      c++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRst busy", 64'(busy), 64'd0);
    checkOutput("midRst done", 64'(done), 64'd0);
    checkStats("midRst", 0, 0, 0);
    checkOutput("midRst op_a", 64'(opA), 64'd1);
    checkOutput("midRst op_b", 64'(opB), 64'd0);
    modelRun(32'hACE1, 100, 2'd3, mc, ms, mm);
    applyStimulus("afterRst", 2'd3, 32'hACE1, 100, mc, ms, mm, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

endmodule
